// File: rtl/mips_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : mips_ctrl_pkg
// Brief    : Shared states, opcode/funct codes and select encodings for the
//            MIPS multicycle controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_BNEEX   = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_JEX     = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef logic [2:0] alu_op_t;
   localparam alu_op_t ALU_ADD = 3'b010;
   localparam alu_op_t ALU_SUB = 3'b110;
   localparam alu_op_t ALU_AND = 3'b000;
   localparam alu_op_t ALU_OR  = 3'b001;
   localparam alu_op_t ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : mips_multicycle_ctrl_if
// Brief    : Controller <-> datapath bundle: instruction fields and ALU flags
//            in, selects and write enables out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mips_multicycle_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       ovf;
   logic [2:0] alucontrol;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic       pcen;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       illegal;

   modport master (
      input  op, funct, zero, ovf,
      output alucontrol, alusrca, alusrcb, pcsrc, pcen, iord,
             memwrite, irwrite, regdst, memtoreg, regwrite, illegal
   );

   modport slave (
      output op, funct, zero, ovf,
      input  alucontrol, alusrca, alusrcb, pcsrc, pcen, iord,
             memwrite, irwrite, regdst, memtoreg, regwrite, illegal
   );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
//------------------------------------------------------------------------------
// Module   : mips_alu_decoder
// Brief    : R-type funct field to ALU operation, with illegal-funct flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  wire logic [5:0] i_funct,
   output alu_op_t         o_alucontrol,
   output logic            o_illegal_funct,
   output logic            o_addsub
);

   always_comb begin
      o_alucontrol    = ALU_ADD;
      o_illegal_funct = 1'b0;
      o_addsub        = 1'b0;
      case (i_funct)
         FUNCT_ADD: o_addsub = 1'b1;
         FUNCT_SUB: begin
            o_alucontrol = ALU_SUB;
            o_addsub     = 1'b1;
         end
         FUNCT_AND: o_alucontrol = ALU_AND;
         FUNCT_OR:  o_alucontrol = ALU_OR;
         FUNCT_SLT: o_alucontrol = ALU_SLT;
         default:   o_illegal_funct = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mips_multicycle_ctrl
// Brief    : Multicycle MIPS control FSM driving ALU selects and all datapath
//            write enables.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             rst_n,
   mips_multicycle_ctrl_if.master bus
);

   state_t     r_state;
   state_t     w_next;
   alu_op_t    w_dec_alu;
   logic       w_dec_illegal;
   logic       w_dec_addsub;
   alu_op_t    w_alucontrol;
   logic       w_alusrca;
   logic [1:0] w_alusrcb;
   logic [1:0] w_pcsrc;
   logic       w_pcen;
   logic       w_iord;
   logic       w_memwrite;
   logic       w_irwrite;
   logic       w_regdst;
   logic       w_memtoreg;
   logic       w_regwrite;
   logic       w_illegal;

   mips_alu_decoder u_alu_decoder (
      .i_funct         (bus.funct),
      .o_alucontrol    (w_dec_alu),
      .o_illegal_funct (w_dec_illegal),
      .o_addsub        (w_dec_addsub)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_alucontrol = ALU_ADD;
      w_alusrca    = 1'b0;
      w_alusrcb    = SRCB_REG;
      w_pcsrc      = PCSRC_ALU;
      w_pcen       = 1'b0;
      w_iord       = 1'b0;
      w_memwrite   = 1'b0;
      w_irwrite    = 1'b0;
      w_regdst     = 1'b0;
      w_memtoreg   = 1'b0;
      w_regwrite   = 1'b0;
      w_illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_irwrite = 1'b1;
            w_alusrcb = SRCB_FOUR;
            w_pcen    = 1'b1;
            w_next    = S_DECODE;
         end
         S_DECODE: begin
            // Branch target is precomputed into ALUOut while the opcode dispatches
            w_alusrcb = SRCB_IMMSH;
            case (bus.op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_RTYPEEX;
               OP_BEQ:       w_next = S_BEQEX;
               OP_BNE:       w_next = S_BNEEX;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JEX;
               default: begin
                  w_illegal = 1'b1;
                  w_next    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            w_alusrca = 1'b1;
            w_alusrcb = SRCB_IMM;
            w_next    = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            w_iord = 1'b1;
            w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_memtoreg = 1'b1;
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWR: begin
            w_iord     = 1'b1;
            w_memwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_RTYPEEX: begin
            w_alusrca    = 1'b1;
            w_alucontrol = w_dec_alu;
            w_illegal    = w_dec_illegal;
            w_next       = (bus.ovf && w_dec_addsub) ? S_FETCH : S_RTYPEWB;
         end
         S_RTYPEWB: begin
            w_regdst   = 1'b1;
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_BEQEX, S_BNEEX: begin
            w_alusrca    = 1'b1;
            w_alucontrol = ALU_SUB;
            w_pcsrc      = PCSRC_ALUOUT;
            w_pcen       = (r_state == S_BEQEX) ? bus.zero : !bus.zero;
            w_next       = S_FETCH;
         end
         S_ADDIEX: begin
            w_alusrca = 1'b1;
            w_alusrcb = SRCB_IMM;
            w_next    = bus.ovf ? S_FETCH : S_ADDIWB;
         end
         S_ADDIWB: begin
            w_regwrite = 1'b1;
            w_next     = S_FETCH;
         end
         S_JEX: begin
            w_pcsrc = PCSRC_JUMP;
            w_pcen  = 1'b1;
            w_next  = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Enables are gated by rst_n so an aborted instruction never writes back
   assign bus.pcen       = w_pcen     & rst_n;
   assign bus.irwrite    = w_irwrite  & rst_n;
   assign bus.memwrite   = w_memwrite & rst_n;
   assign bus.regwrite   = w_regwrite & rst_n;
   assign bus.illegal    = w_illegal  & rst_n;
   assign bus.alucontrol = w_alucontrol;
   assign bus.alusrca    = w_alusrca;
   assign bus.alusrcb    = w_alusrcb;
   assign bus.pcsrc      = w_pcsrc;
   assign bus.iord       = w_iord;
   assign bus.regdst     = w_regdst;
   assign bus.memtoreg   = w_memtoreg;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mips_multicycle_ctrl
// Brief    : Directed and random-stream self-checking bench for the controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_multicycle_ctrl;

   // {alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, memwrite, irwrite,
   //  regdst, memtoreg, regwrite, illegal}
   localparam logic [15:0] V_RST     = 16'b010_0_01_00_0_0_0_0_0_0_0_0;
   localparam logic [15:0] V_FETCH   = 16'b010_0_01_00_1_0_0_1_0_0_0_0;
   localparam logic [15:0] V_DECODE  = 16'b010_0_11_00_0_0_0_0_0_0_0_0;
   localparam logic [15:0] V_DEC_ILL = 16'b010_0_11_00_0_0_0_0_0_0_0_1;
   localparam logic [15:0] V_MEMADR  = 16'b010_1_10_00_0_0_0_0_0_0_0_0;
   localparam logic [15:0] V_MEMRD   = 16'b010_0_00_00_0_1_0_0_0_0_0_0;
   localparam logic [15:0] V_MEMWB   = 16'b010_0_00_00_0_0_0_0_0_1_1_0;
   localparam logic [15:0] V_MEMWR   = 16'b010_0_00_00_0_1_1_0_0_0_0_0;
   localparam logic [15:0] V_RSUB    = 16'b110_1_00_00_0_0_0_0_0_0_0_0;
   localparam logic [15:0] V_RILL    = 16'b010_1_00_00_0_0_0_0_0_0_0_1;
   localparam logic [15:0] V_RTYPEWB = 16'b010_0_00_00_0_0_0_0_1_0_1_0;
   localparam logic [15:0] V_BR_TK   = 16'b110_1_00_01_1_0_0_0_0_0_0_0;
   localparam logic [15:0] V_BR_NT   = 16'b110_1_00_01_0_0_0_0_0_0_0_0;
   localparam logic [15:0] V_ADDIEX  = 16'b010_1_10_00_0_0_0_0_0_0_0_0;
   localparam logic [15:0] V_ADDIWB  = 16'b010_0_00_00_0_0_0_0_0_0_1_0;
   localparam logic [15:0] V_JEX     = 16'b010_0_00_10_1_0_0_0_0_0_0_0;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   mips_multicycle_ctrl_if bus ();

   mips_multicycle_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] snap();
      return {bus.alucontrol, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen,
              bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
              bus.regwrite, bus.illegal};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic z, input logic v);
      bus.op    = o;
      bus.funct = f;
      bus.zero  = z;
      bus.ovf   = v;
      #1;
   endtask

   initial begin
      logic [5:0] ops [8];
      logic [5:0] fns [6];
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
              6'b000101, 6'b001000, 6'b000010, 6'b111111};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      set_in(6'b100011, 6'b100000, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      chk("reset", snap(), V_RST);
      rst_n = 1'b1;
      #1;
      chk("lw_fetch", snap(), V_FETCH);
      tick(); chk("lw_decode", snap(), V_DECODE);
      tick(); chk("lw_memadr", snap(), V_MEMADR);
      tick(); chk("lw_memrd", snap(), V_MEMRD);
      tick(); chk("lw_memwb", snap(), V_MEMWB);
      tick(); chk("lw_next_fetch", snap(), V_FETCH);

      // reset asserted during MEMRD aborts the load
      tick(); tick(); tick();
      chk("lw2_memrd", snap(), V_MEMRD);
      rst_n = 1'b0;
      #1; chk("abort_async", snap(), V_RST);
      tick(); chk("abort_held", snap(), V_RST);
      rst_n = 1'b1;
      #1; chk("abort_release", snap(), V_FETCH);

      // R-type sub, no overflow
      set_in(6'b000000, 6'b100010, 1'b0, 1'b0);
      tick(); chk("rsub_decode", snap(), V_DECODE);
      tick(); chk("rsub_ex", snap(), V_RSUB);
      tick(); chk("rsub_wb", snap(), V_RTYPEWB);
      tick(); chk("rsub_fetch", snap(), V_FETCH);

      // R-type sub with overflow: writeback suppressed
      set_in(6'b000000, 6'b100010, 1'b0, 1'b1);
      tick(); tick(); chk("rsub_ovf_ex", snap(), V_RSUB);
      tick(); chk("rsub_ovf_fetch", snap(), V_FETCH);

      // beq taken / not taken, bne taken
      set_in(6'b000100, 6'b000000, 1'b1, 1'b0);
      tick(); tick(); chk("beq_taken", snap(), V_BR_TK);
      bus.zero = 1'b0; #1;
      chk("beq_not_taken", snap(), V_BR_NT);
      tick(); chk("beq_fetch", snap(), V_FETCH);
      set_in(6'b000101, 6'b000000, 1'b0, 1'b0);
      tick(); tick(); chk("bne_taken", snap(), V_BR_TK);
      tick(); chk("bne_fetch", snap(), V_FETCH);

      // sw
      set_in(6'b101011, 6'b000000, 1'b0, 1'b0);
      tick(); chk("sw_decode", snap(), V_DECODE);
      tick(); chk("sw_memadr", snap(), V_MEMADR);
      tick(); chk("sw_memwr", snap(), V_MEMWR);
      tick(); chk("sw_fetch", snap(), V_FETCH);

      // addi normal and overflow, jump
      set_in(6'b001000, 6'b000000, 1'b0, 1'b0);
      tick(); tick(); chk("addi_ex", snap(), V_ADDIEX);
      tick(); chk("addi_wb", snap(), V_ADDIWB);
      tick(); chk("addi_fetch", snap(), V_FETCH);
      set_in(6'b001000, 6'b000000, 1'b0, 1'b1);
      tick(); tick(); chk("addi_ovf_ex", snap(), V_ADDIEX);
      tick(); chk("addi_ovf_fetch", snap(), V_FETCH);
      set_in(6'b000010, 6'b000000, 1'b0, 1'b0);
      tick(); tick(); chk("j_ex", snap(), V_JEX);
      tick(); chk("j_fetch", snap(), V_FETCH);

      // illegal opcode and illegal funct
      set_in(6'b111111, 6'b000000, 1'b0, 1'b0);
      tick(); chk("illop_decode", snap(), V_DEC_ILL);
      tick(); chk("illop_fetch", snap(), V_FETCH);
      set_in(6'b000000, 6'b000000, 1'b0, 1'b1);
      tick(); tick(); chk("illfn_ex", snap(), V_RILL);
      tick(); chk("illfn_wb", snap(), V_RTYPEWB);
      tick(); chk("illfn_fetch", snap(), V_FETCH);

      // random instruction stream with cycle-count and enable exclusivity checks
      for (int n = 0; n < 1000; n++) begin
         int         ncyc;
         logic [5:0] o;
         logic [5:0] f;
         logic       z;
         logic       v;
         o = ops[$urandom_range(7, 0)];
         f = fns[$urandom_range(5, 0)];
         z = 1'($urandom_range(1, 0));
         v = 1'($urandom_range(1, 0));
         set_in(o, f, z, v);
         case (o)
            6'b100011: ncyc = 5;
            6'b101011: ncyc = 4;
            6'b000000: ncyc = (v && (f == 6'b100000 || f == 6'b100010)) ? 3 : 4;
            6'b001000: ncyc = v ? 3 : 4;
            6'b111111: ncyc = 2;
            default:   ncyc = 3;
         endcase
         chk("rnd_fetch_en", {14'd0, bus.irwrite, bus.pcen}, 16'b11);
         for (int c = 1; c < ncyc; c++) begin
            tick();
            chk("rnd_no_irwrite", {15'd0, bus.irwrite}, 16'd0);
            chk("rnd_onehot_we",
                {15'd0, ($countones({bus.irwrite, bus.memwrite, bus.regwrite}) <= 1)},
                16'd1);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
